// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST engine for one 1-port bit-mask SRAM macro.
// Drives the macro BIST port, compares read data one cycle after each read,
// and reports pass/fail plus the address and element of the first mismatch.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | macro on functional port, waiting for start_i
// SETUP | bist_en_o high, no access, lets the macro input mux settle
// RUN   | one march op per cycle, compare of the previous read
// DRAIN | no access, compare of the final read in flight
// DONE  | result held, start_i re-arms the engine
module sram_march_bist_ctrl #(
  parameter int AddrWidth = 6,
  parameter int DataWidth = 64,
  parameter logic [DataWidth-1:0] Background = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 bist_en_o,
  output logic [AddrWidth-1:0] bist_addr_o,
  output logic [DataWidth-1:0] bist_din_o,
  output logic [DataWidth-1:0] bist_bm_o,
  output logic                 bist_men_o,
  output logic                 bist_wen_o,
  output logic                 bist_ren_o,
  input  logic [DataWidth-1:0] bist_dout_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [2:0]           fail_elem_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [AddrWidth-1:0] AddrMax = '1;

  logic [2:0]           state, state_nxt;
  logic [2:0]           elem;
  logic [AddrWidth-1:0] addr;
  logic                 phase;

  logic                 pass_q;
  logic [AddrWidth-1:0] fail_addr_q;
  logic [2:0]           fail_elem_q;

  logic                 cmp_valid;
  logic [DataWidth-1:0] exp_data;
  logic [AddrWidth-1:0] exp_addr;
  logic [2:0]           exp_elem;

  logic                 start_ok;
  logic                 elem_down;
  logic                 elem_single;
  logic                 op_read;
  logic                 op_final_at_addr;
  logic                 at_end;
  logic                 last_op;
  logic                 mismatch;
  logic [DataWidth-1:0] wr_data;
  logic [DataWidth-1:0] rd_data;

  // Decode of the current march element and position
  always_comb begin
    start_ok         = (state == ST_IDLE || state == ST_DONE) && start_i;
    elem_down        = (elem == 3'd3) || (elem == 3'd4);
    elem_single      = (elem == 3'd0) || (elem == 3'd5);
    // 2-op elements read in phase 0 and write in phase 1; M5 only reads
    op_read          = (elem == 3'd5) || ((elem != 3'd0) && !phase);
    op_final_at_addr = elem_single || phase;
    at_end           = elem_down ? (addr == '0) : (addr == AddrMax);
    last_op          = (elem == 3'd5) && at_end;
    // w1 in M1/M3, w0 otherwise; r1 expected in M2/M4, r0 otherwise
    wr_data          = ((elem == 3'd1) || (elem == 3'd3)) ? ~Background : Background;
    rd_data          = ((elem == 3'd2) || (elem == 3'd4)) ? ~Background : Background;
    mismatch         = cmp_valid && pass_q && (bist_dout_i != exp_data);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_i) state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = ST_RUN;
      ST_RUN:   if (last_op || mismatch) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  if (start_i) state_nxt = ST_SETUP;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Address / element / phase sequencing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem  <= 3'd0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (start_ok) begin
      elem  <= 3'd0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (state == ST_RUN) begin
      if (op_final_at_addr) begin
        phase <= 1'b0;
        if (at_end) begin
          elem <= elem + 3'd1;
          // M2 and M3 are followed by the down-direction elements
          addr <= ((elem == 3'd2) || (elem == 3'd3)) ? AddrMax : '0;
        end else begin
          addr <= elem_down ? (addr - 1'b1) : (addr + 1'b1);
        end
      end else begin
        phase <= 1'b1;
      end
    end
  end

  // Read-compare pipeline: capture expectation when a read issues
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_valid <= 1'b0;
      exp_data  <= '0;
      exp_addr  <= '0;
      exp_elem  <= 3'd0;
    end else begin
      cmp_valid <= (state == ST_RUN) && op_read;
      if ((state == ST_RUN) && op_read) begin
        exp_data <= rd_data;
        exp_addr <= addr;
        exp_elem <= elem;
      end
    end
  end

  // Pass/fail status: re-armed on SETUP entry, first mismatch wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else if (start_ok) begin
      pass_q      <= 1'b1;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else if (mismatch) begin
      pass_q      <= 1'b0;
      fail_addr_q <= exp_addr;
      fail_elem_q <= exp_elem;
    end
  end

  // Macro port drive: quiet (all zero) except for the op issued in RUN
  always_comb begin
    busy_o      = (state == ST_SETUP) || (state == ST_RUN) || (state == ST_DRAIN);
    done_o      = (state == ST_DONE);
    bist_en_o   = busy_o;
    bist_men_o  = 1'b0;
    bist_wen_o  = 1'b0;
    bist_ren_o  = 1'b0;
    bist_addr_o = '0;
    bist_din_o  = '0;
    bist_bm_o   = '0;
    if (state == ST_RUN) begin
      bist_men_o  = 1'b1;
      bist_wen_o  = !op_read;
      bist_ren_o  = op_read;
      bist_addr_o = addr;
      bist_din_o  = op_read ? '0 : wr_data;
      bist_bm_o   = '1;
    end
    pass_o      = pass_q;
    fail_addr_o = fail_addr_q;
    fail_elem_o = fail_elem_q;
  end

endmodule
